// File: rtl/pf_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package pf_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } pf_entry_t;

  localparam int unsigned ENTRY_W = $bits(pf_entry_t);

endpackage

// File: rtl/pf_fifo.sv
// Synchronous FIFO with flush and a registered head that tracks the
// entry that will be at the front after this cycle's push/pop.
module pf_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_after_pop;
  logic [CNT_W-1:0] count_next;
  logic             push_eff;
  logic             pop_eff;
  logic [WIDTH-1:0] head_next;

  // Head lookahead: an existing entry if one survives the pop, else the word being pushed.
  always_comb begin
    push_eff        = push & ~flush;
    pop_eff         = pop & ~flush & (count != '0);
    rd_ptr_next     = rd_ptr + PTR_W'(pop_eff);
    count_after_pop = count - CNT_W'(pop_eff);
    count_next      = count_after_pop + CNT_W'(push_eff);
    head_next       = head;
    if (count_after_pop != '0) begin
      head_next = mem[rd_ptr_next];
    end else if (push_eff) begin
      head_next = wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_eff) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr + PTR_W'(push_eff);
      count  <= count_next;
      valid  <= (count_next != '0);
      head   <= head_next;
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction fetch front end: issues word requests over req/ack, queues
// returned words with their PC, and restarts fetch on redirect.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic        instr_ready
);

  import pf_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_next;
  logic [31:0]      fetch_pc_inc;
  logic [31:0]      addr_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after_pop;
  logic             pop;
  logic             push;
  pf_entry_t        push_entry;
  pf_entry_t        head_entry;
  logic [ENTRY_W-1:0] head_bits;

  // Next-state: a request is only issued when its response already has a slot.
  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    addr_next       = imem_addr;
    push            = 1'b0;
    fetch_pc_inc    = fetch_pc + PC_STEP;
    pop             = instr_valid & instr_ready & ~redirect_valid;
    count_after_pop = count - CNT_W'(pop);
    push_entry      = '{pc: fetch_pc, pc_plus4: fetch_pc_inc, instr: imem_rdata};

    if (redirect_valid) begin
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
      case (state)
        S_WAIT, S_DISCARD: state_next = imem_ack ? S_IDLE : S_DISCARD;
        default:           state_next = S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (count_after_pop < DEPTH_C) begin
            state_next = S_WAIT;
            addr_next  = fetch_pc;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc_inc;
            if ((count_after_pop + CNT_W'(1)) < DEPTH_C) begin
              addr_next = fetch_pc_inc;
            end else begin
              state_next = S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (imem_ack) begin
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      imem_addr <= addr_next;
      imem_req  <= (state_next == S_WAIT) || (state_next == S_DISCARD);
    end
  end

  pf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .flush (redirect_valid),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .head  (head_bits),
    .valid (instr_valid),
    .count (count)
  );

  assign head_entry     = pf_entry_t'(head_bits);
  assign instr          = head_entry.instr;
  assign instr_pc       = head_entry.pc;
  assign instr_pc_plus4 = head_entry.pc_plus4;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench: a variable-latency memory model feeds expected entries
// into a queue; a monitor compares every decode-side handshake against it.
module tb_instr_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr_ready = 1'b0;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .instr_ready    (instr_ready)
  );

  always #5 CLK = ~CLK;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic [31:0] next_fetch = RESET_PC;
  bit   stale = 1'b0;
  int   ack_cnt = 0;
  int   pops = 0;
  bit   seen_wrap = 1'b0;
  int   lat_min = 0;
  int   lat_max = 0;
  int   wait_cnt = 0;
  int   cur_lat = 0;
  bit   pending = 1'b0;
  exp_t push_e;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait expired at t=%0t", name, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
  endtask

  // Memory: each request waits a random number of cycles, then returns addr^KEY.
  always @(posedge CLK) begin
    #1;
    if (!imem_req) begin
      pending = 1'b0;
    end else if (!pending) begin
      pending  = 1'b1;
      wait_cnt = 0;
      cur_lat  = int'($urandom_range(lat_max, lat_min));
    end else begin
      wait_cnt++;
    end
    imem_ack   = imem_req && pending && (wait_cnt >= cur_lat);
    imem_rdata = imem_ack ? (imem_addr ^ KEY) : $urandom;
    if (imem_ack) pending = 1'b0;
  end

  // Reference model: the stream decode sees is consecutive words from the last redirect target.
  always @(negedge CLK) begin
    if (RESET) begin
      exp_q.delete();
      next_fetch = RESET_PC;
      stale      = 1'b0;
      ack_cnt    = 0;
    end else if (redirect_valid) begin
      if (imem_ack) ack_cnt++;
      exp_q.delete();
      next_fetch = redirect_pc & ~32'd3;
      stale      = imem_req && !imem_ack;
    end else if (imem_ack) begin
      ack_cnt++;
      if (stale) begin
        stale = 1'b0;
      end else begin
        chk("ack_addr", imem_addr, next_fetch);
        push_e.pc    = next_fetch;
        push_e.pc4   = next_fetch + 32'd4;
        push_e.instr = next_fetch ^ KEY;
        exp_q.push_back(push_e);
        next_fetch = next_fetch + 32'd4;
        chk("occupancy_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
      end
    end
  end

  // Monitor: every accepted head must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!RESET && instr_valid && instr_ready && !redirect_valid) begin
      pops++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got pc %h, expected no entry", instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("head_pc", instr_pc, mon_e.pc);
        chk("head_pc_plus4", instr_pc_plus4, mon_e.pc4);
        chk("head_instr", instr, mon_e.instr);
        if (mon_e.pc == 32'hFFFF_FFFC) seen_wrap = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;

    // Reset values, then zero-wait streaming
    lat_min = 0; lat_max = 0; instr_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr_pc_plus4", instr_pc_plus4, 32'h0);
    RESET = 1'b0;
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    tick();
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_pc", instr_pc, 32'h0);
    chk("first_instr", instr, KEY);
    tick();
    chk("second_addr", imem_addr, 32'h8);
    repeat (20) tick();

    // Backpressure: queue fills with four words then fetch stops
    instr_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    chk("full_ack_count", 32'(ack_cnt), 32'd4);
    chk("full_req_low", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (12) tick();

    // Redirect during a slow request: stale word is discarded
    lat_min = 3; lat_max = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    if (!found) timeout_fail("wait_addr8");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("discard_req_held", 32'(imem_req), 32'd1);
    chk("discard_addr_held", imem_addr, 32'h8);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (imem_req && imem_addr != 32'h8) found = 1'b1;
    end
    if (!found) timeout_fail("wait_after_discard");
    chk("redirect_target_addr", imem_addr, 32'h100);
    repeat (15) tick();

    // Redirect coinciding with ack and pop while two entries are queued
    lat_min = 0; lat_max = 0; instr_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (exp_q.size() == 2) found = 1'b1;
    end
    if (!found) timeout_fail("wait_two_queued");
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("flush_valid_low", 32'(instr_valid), 32'd0);
    chk("flush_req_low", 32'(imem_req), 32'd0);
    tick();
    chk("flush_new_req", 32'(imem_req), 32'd1);
    chk("flush_new_addr", imem_addr, 32'h200);
    repeat (10) tick();

    // Address wrap at the top of the 32-bit space
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    chk("wrap_seen", 32'(seen_wrap), 32'd1);

    // Asynchronous reset mid-request with entries queued
    lat_min = 3; lat_max = 3; instr_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (exp_q.size() == 2 && imem_req) found = 1'b1;
    end
    if (!found) timeout_fail("wait_two_in_wait");
    #1 RESET = 1'b1;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #2 RESET = 1'b0;
    tick();
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RESET_PC);

    // Randomised traffic: latency, backpressure and redirects
    lat_min = 0; lat_max = 3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) lat_max = int'($urandom_range(0, 3));
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: redirect_pc = 32'($urandom_range(0, 255));
      endcase
      tick();
    end
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (20) tick();
    chk("liveness", 32'(pops > 500), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
